// File: rtl/dffnq_scan_pkg.sv
// Shared types for the dffnq scan-chain sequencer: command opcodes, FSM states
// and the width helper for the shared phase counter.
package dffnq_scan_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_SHIFT         = 2'b00,
        OP_CAPTURE       = 2'b01,
        OP_CAPTURE_SHIFT = 2'b10,
        OP_RSVD          = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SHIFT,
        RESP
    } state_t;

    // One counter serves both phases, so it must hold the longer of the two.
    function automatic int cnt_width(input int chain_len, input int capture_cycles);
        int longest;
        longest = (chain_len > capture_cycles) ? chain_len : capture_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/dffnq_scan_sequencer_if.sv
// Command/response bus between the test controller (master) and the scan
// sequencer (slave).
interface dffnq_scan_sequencer_if
    import dffnq_scan_pkg::*;
#(
    parameter int CHAIN_LEN = 16
) ();

    logic                 req_valid;
    logic                 req_ready;
    logic [OP_W-1:0]      req_op;
    logic [CHAIN_LEN-1:0] req_data;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [CHAIN_LEN-1:0] rsp_data;
    logic                 rsp_err;

    modport master (
        output req_valid, req_op, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/dffnq_scan_counter.sv
// Loadable down-counter with terminal flag; holds at zero instead of wrapping.
module dffnq_scan_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    assign tc = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !tc) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/dffnq_scan_sequencer.sv
// Drives a falling-edge dffnq scan chain (CE/SE/SI) for shift, capture and
// capture-then-shift commands, collecting SO into the response word.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a command; REQ_READY high unless a response is held
// CAPTURE | CAPTURE_CYCLES functional pulses (CE=1, SE=0)
// SHIFT   | CHAIN_LEN scan pulses, SI MSB first, SO sampled each cycle
// RESP    | first cycle raises RSP_VALID, then waits for RSP_READY
module dffnq_scan_sequencer
    import dffnq_scan_pkg::*;
#(
    parameter int CHAIN_LEN      = 16,
    parameter int CAPTURE_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    dffnq_scan_sequencer_if.slave  bus,
    output logic                   ce,
    output logic                   se,
    output logic                   si,
    input  logic                   so,
    output logic                   busy
);

    localparam int               CNT_W      = cnt_width(CHAIN_LEN, CAPTURE_CYCLES);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(CAPTURE_CYCLES - 1);

    state_t               state_q, state_d;
    op_t                  op_q, op_d;
    logic [CHAIN_LEN-1:0] req_sr_q, req_sr_d;
    logic [CHAIN_LEN-1:0] rsp_sr_q, rsp_sr_d;
    logic                 ce_q, ce_d, se_q, se_d, si_q, si_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 req_ready_q;

    logic                 accept;
    logic                 shift_now;
    logic [CHAIN_LEN-1:0] shift_src;
    logic                 cnt_load, cnt_dec, cnt_tc;
    logic [CNT_W-1:0]     cnt_val, cnt_count;

    dffnq_scan_counter #(.WIDTH(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .count    (cnt_count),
        .tc       (cnt_tc)
    );

    assign accept = bus.req_valid && req_ready_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        req_sr_d    = req_sr_q;
        rsp_sr_d    = rsp_sr_q;
        ce_d        = 1'b0;
        se_d        = 1'b0;
        si_d        = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        cnt_load    = 1'b0;
        cnt_val     = '0;
        cnt_dec     = 1'b0;
        shift_now   = 1'b0;
        shift_src   = req_sr_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d     = op_t'(bus.req_op);
                    rsp_sr_d = '0;
                    unique case (op_t'(bus.req_op))
                        OP_SHIFT: begin
                            state_d   = SHIFT;
                            cnt_load  = 1'b1;
                            cnt_val   = SHIFT_LAST;
                            shift_now = 1'b1;
                            shift_src = bus.req_data;
                        end
                        OP_CAPTURE, OP_CAPTURE_SHIFT: begin
                            state_d  = CAPTURE;
                            cnt_load = 1'b1;
                            cnt_val  = CAP_LAST;
                            ce_d     = 1'b1;
                            req_sr_d = bus.req_data;
                        end
                        default: state_d = RESP;
                    endcase
                end
            end
            CAPTURE: begin
                if (!cnt_tc) begin
                    cnt_dec = 1'b1;
                    ce_d    = 1'b1;
                end else if (op_q == OP_CAPTURE_SHIFT) begin
                    state_d   = SHIFT;
                    cnt_load  = 1'b1;
                    cnt_val   = SHIFT_LAST;
                    shift_now = 1'b1;
                end else begin
                    state_d = RESP;
                end
            end
            SHIFT: begin
                // CE is already low on the edge into RESP, so no extra chain edge.
                if (!cnt_tc) begin
                    cnt_dec   = 1'b1;
                    shift_now = 1'b1;
                end else begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (op_q == OP_RSVD);
                end else if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // SO is sampled on the edge that starts each shift cycle, before its falling-edge shift.
        if (shift_now) begin
            ce_d     = 1'b1;
            se_d     = 1'b1;
            si_d     = shift_src[CHAIN_LEN-1];
            req_sr_d = {shift_src[CHAIN_LEN-2:0], 1'b0};
            rsp_sr_d = {rsp_sr_d[CHAIN_LEN-2:0], so};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_SHIFT;
            req_sr_q    <= '0;
            rsp_sr_q    <= '0;
            ce_q        <= 1'b0;
            se_q        <= 1'b0;
            si_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            req_sr_q    <= req_sr_d;
            rsp_sr_q    <= rsp_sr_d;
            ce_q        <= ce_d;
            se_q        <= se_d;
            si_q        <= si_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            req_ready_q <= (state_d == IDLE) && !rsp_valid_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_sr_q;
    assign bus.rsp_err   = rsp_err_q;
    assign ce            = ce_q;
    assign se            = se_q;
    assign si            = si_q;
    assign busy          = (state_q != IDLE);

endmodule
